// File: rtl/snn_float_pkg.sv
// Float constants, neuron reset-model encodings and controller states shared by
// the potential adder array and its float helpers.
package snn_float_pkg;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP_SIGN_BIT = 32'h8000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  localparam logic [1:0] MODEL_HARD = 2'b00;
  localparam logic [1:0] MODEL_SOFT = 2'b01;
  localparam logic [1:0] MODEL_NONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIRE  = 2'd3
  } state_e;

endpackage

// File: rtl/potential_adder_array_if.sv
// Weight-event stream into the potential adder array.
interface potential_adder_array_if #(
  parameter int ID_W = 2
) ();
  // An event transfers on a rising clock edge where in_valid && in_ready; the
  // master holds in_id/in_weight stable while in_valid is high and not yet taken.
  logic            in_valid;
  logic            in_ready;
  logic [ID_W-1:0] in_id;
  logic [31:0]     in_weight;

  modport master (output in_valid, output in_id, output in_weight, input in_ready);
  modport slave  (input in_valid, input in_id, input in_weight, output in_ready);
endinterface

// File: rtl/fp_add.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with denormal, infinity and NaN handling.
module fp_add (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  logic        a_big, a_nan, b_nan, a_inf, b_inf, up;
  logic [31:0] x, y;
  logic [7:0]  ex, ey, d;
  logic [26:0] mx, my, my_sh, mn;
  logic [27:0] acc;
  logic [8:0]  e;
  logic [4:0]  lz, sh;
  logic [24:0] rnd;

  always_comb begin
    a_nan = (&a_i[30:23]) && (|a_i[22:0]);
    b_nan = (&b_i[30:23]) && (|b_i[22:0]);
    a_inf = (&a_i[30:23]) && !(|a_i[22:0]);
    b_inf = (&b_i[30:23]) && !(|b_i[22:0]);
    // x is the operand of larger magnitude; it also decides the result sign
    a_big = (a_i[30:0] >= b_i[30:0]);
    x     = a_big ? a_i : b_i;
    y     = a_big ? b_i : a_i;
    ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx    = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    my    = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    d     = ex - ey;
    my_sh = '0;
    acc   = '0;
    mn    = '0;
    lz    = '0;
    sh    = '0;
    e     = {1'b0, ex};
    if (d >= 8'd27) begin
      my_sh = {26'd0, |my};
    end else begin
      my_sh    = my >> d;
      my_sh[0] = my_sh[0] | (|(my & ((27'd1 << d) - 27'd1)));
    end
    if (x[31] == y[31]) begin
      acc = {1'b0, mx} + {1'b0, my_sh};
      if (acc[27]) begin
        mn    = acc[27:1];
        mn[0] = acc[1] | acc[0];
        e     = e + 9'd1;
      end else begin
        mn = acc[26:0];
      end
    end else begin
      acc = {1'b0, mx} - {1'b0, my_sh};
      mn  = acc[26:0];
      lz  = 5'd27;
      for (int i = 0; i < 27; i++) begin
        if (mn[i]) lz = 5'(26 - i);
      end
      // stop normalising at the minimum exponent so tiny results stay denormal
      sh = (9'(lz) < e) ? lz : 5'(e - 9'd1);
      mn = mn << sh;
      e  = e - 9'(sh);
    end
    up  = mn[2] & (mn[1] | mn[0] | mn[3]);
    rnd = {1'b0, mn[26:3]} + {24'd0, up};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 9'd1;
    end
    if (e >= 9'd255) sum_o = {x[31], 8'hFF, 23'd0};
    else             sum_o = {x[31], (rnd[23] ? e[7:0] : 8'd0), rnd[22:0]};
    if ((x[31] != y[31]) && (acc[26:0] == 27'd0)) sum_o = 32'h0000_0000;
    if (a_nan || b_nan)                           sum_o = 32'h7FC0_0000;
    else if (a_inf && b_inf && (a_i[31] != b_i[31])) sum_o = 32'h7FC0_0000;
    else if (a_inf)                               sum_o = a_i;
    else if (b_inf)                               sum_o = b_i;
  end
endmodule

// File: rtl/fp_ge.sv
// Combinational float a >= b: signed zeros are equal, NaN never compares true.
module fp_ge
  import snn_float_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        ge_o
);
  logic        a_nan, b_nan, both_zero;
  logic [31:0] ka, kb;

  assign a_nan     = (&a_i[30:23]) && (|a_i[22:0]);
  assign b_nan     = (&b_i[30:23]) && (|b_i[22:0]);
  assign both_zero = (a_i[30:0] == 31'd0) && (b_i[30:0] == 31'd0);
  // map sign-magnitude onto an unsigned key that orders like the real values
  assign ka = a_i[31] ? ~a_i : (a_i | FP_SIGN_BIT);
  assign kb = b_i[31] ? ~b_i : (b_i | FP_SIGN_BIT);
  assign ge_o = !a_nan && !b_nan && (both_zero || (ka >= kb));
endmodule

// File: rtl/potential_adder_array.sv
// Time-multiplexed membrane potential store: pipelined weight accumulation,
// then a one-neuron-per-cycle threshold scan with model-selected reset.
module potential_adder_array
  import snn_float_pkg::*;
#(
  parameter int          NEURONS = 4,
  parameter int          ID_W    = $clog2(NEURONS),
  parameter logic [31:0] V_RESET = FP_ZERO
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            model,
  input  logic [31:0]           v_threshold,
  input  logic                  ts_start,
  input  logic                  ts_end,
  potential_adder_array_if.slave ev,
  input  logic                  ld_en,
  input  logic [ID_W-1:0]       ld_id,
  input  logic [31:0]           ld_data,
  input  logic [ID_W-1:0]       rd_id,
  output logic [31:0]           rd_data,
  output logic                  spike_valid,
  output logic [ID_W-1:0]       spike_id,
  output logic [NEURONS-1:0]    spike_vec,
  output logic                  busy,
  output logic                  done,
  output state_e                dbg_state
);
  localparam logic [ID_W-1:0] LAST = ID_W'(NEURONS - 1);

  state_e             state_q;
  logic               s1_valid_q, s2_valid_q;
  logic [ID_W-1:0]    s1_id_q, s2_id_q, scan_q;
  logic [31:0]        s1_w_q, s2_w_q, s2_op_q;
  logic [31:0]        pot_q [NEURONS];
  logic               spike_valid_q, done_q;
  logic [ID_W-1:0]    spike_id_q;
  logic [NEURONS-1:0] spike_vec_q, spike_acc_q, spike_acc_d;
  logic [31:0]        add_a, add_b, add_sum, s2_op_d, scan_pot;
  logic               accept, fire_ge, fire;

  assign ev.in_ready = (state_q == ST_ACCUM);
  assign accept      = ev.in_valid && ev.in_ready;
  assign scan_pot    = pot_q[scan_q];

  // one adder serves accumulation and soft reset; the pipeline is empty in FIRE
  assign add_a = (state_q == ST_FIRE) ? scan_pot : s2_op_q;
  assign add_b = (state_q == ST_FIRE) ? (v_threshold ^ FP_SIGN_BIT) : s2_w_q;

  fp_add u_add (.a_i(add_a), .b_i(add_b), .sum_o(add_sum));
  fp_ge  u_ge  (.a_i(scan_pot), .b_i(v_threshold), .ge_o(fire_ge));

  assign fire = (state_q == ST_FIRE) && fire_ge;

  // a same-id event one slot ahead has not been written yet: take its sum
  assign s2_op_d = (s2_valid_q && (s2_id_q == s1_id_q)) ? add_sum : pot_q[s1_id_q];

  always_comb begin
    spike_acc_d         = spike_acc_q;
    spike_acc_d[scan_q] = fire_ge;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      s1_id_q       <= '0;
      s2_id_q       <= '0;
      s1_w_q        <= '0;
      s2_w_q        <= '0;
      s2_op_q       <= '0;
      scan_q        <= '0;
      spike_valid_q <= 1'b0;
      spike_id_q    <= '0;
      spike_vec_q   <= '0;
      spike_acc_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      spike_valid_q <= fire;
      if (fire) spike_id_q <= scan_q;
      done_q     <= 1'b0;
      s1_valid_q <= accept;
      if (accept) begin
        s1_id_q <= ev.in_id;
        s1_w_q  <= ev.in_weight;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_id_q <= s1_id_q;
        s2_w_q  <= s1_w_q;
        s2_op_q <= s2_op_d;
      end
      case (state_q)
        ST_IDLE:  if (ts_start) state_q <= ST_ACCUM;
        ST_ACCUM: if (ts_end) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (!s1_valid_q && !s2_valid_q) begin
            state_q     <= ST_FIRE;
            scan_q      <= '0;
            spike_acc_q <= '0;
          end
        end
        ST_FIRE: begin
          spike_acc_q <= spike_acc_d;
          scan_q      <= scan_q + ID_W'(1);
          if (scan_q == LAST) begin
            spike_vec_q <= spike_acc_d;
            done_q      <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NEURONS; i++) pot_q[i] <= V_RESET;
    end else begin
      if ((state_q == ST_IDLE) && ld_en) pot_q[ld_id] <= ld_data;
      if (s2_valid_q) pot_q[s2_id_q] <= add_sum;
      if (fire) begin
        case (model)
          MODEL_SOFT: pot_q[scan_q] <= add_sum;
          MODEL_NONE: ;
          default:    pot_q[scan_q] <= V_RESET;
        endcase
      end
    end
  end

  assign rd_data     = pot_q[rd_id];
  assign spike_valid = spike_valid_q;
  assign spike_id    = spike_id_q;
  assign spike_vec   = spike_vec_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_potential_adder_array.sv
// Directed bench for potential_adder_array: scan vectors from a table plus
// hand sequences for accumulation, coincident ts_end and reset during FIRE.
module tb_potential_adder_array;
  import snn_float_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic              reload;
    logic [1:0]        model;
    logic [31:0]       thr;
    logic [3:0][31:0]  pre;
    logic [3:0]        exp_vec;
    logic [3:0][31:0]  post;
  } vec_t;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [1:0]     model;
  logic [31:0]    v_threshold;
  logic           ts_start, ts_end, ld_en;
  logic [IW-1:0]  ld_id, rd_id, spike_id;
  logic [31:0]    ld_data, rd_data;
  logic           spike_valid, busy, done;
  logic [N-1:0]   spike_vec;
  state_e         dbg_state;

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [IW-1:0]  exp_q[$];
  vec_t           vecs [6];
  logic [31:0]    v;

  potential_adder_array_if #(.ID_W(IW)) ev ();

  potential_adder_array #(.NEURONS(N), .ID_W(IW), .V_RESET(32'h0)) dut (
    .CLK(CLK), .RESET(RESET), .model(model), .v_threshold(v_threshold),
    .ts_start(ts_start), .ts_end(ts_end), .ev(ev),
    .ld_en(ld_en), .ld_id(ld_id), .ld_data(ld_data),
    .rd_id(rd_id), .rd_data(rd_data),
    .spike_valid(spike_valid), .spike_id(spike_id), .spike_vec(spike_vec),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard primitive
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic load_pot(input logic [IW-1:0] id, input logic [31:0] data);
    ld_en = 1'b1; ld_id = id; ld_data = data;
    step();
    ld_en = 1'b0;
  endtask

  task automatic read_pot(input logic [IW-1:0] id, output logic [31:0] val);
    rd_id = id;
    #1;
    val = rd_data;
  endtask

  task automatic pulse_start();
    ts_start = 1'b1; step(); ts_start = 1'b0;
  endtask

  task automatic pulse_end();
    ts_end = 1'b1; step(); ts_end = 1'b0;
  endtask

  task automatic push_spikes(input logic [3:0] vec);
    exp_q.delete();
    for (int j = 0; j < N; j++) if (vec[j]) exp_q.push_back(IW'(j));
  endtask

  // cycles counted from the edge that sampled ts_end; spikes checked against exp_q
  task automatic wait_done(input string name, input int start_c, input int exp_lat);
    int  c;
    int  rdy_hi;
    bit  seen;
    c = start_c; rdy_hi = 0; seen = 1'b0;
    while (!seen && c < 100) begin
      step();
      c++;
      if (ev.in_ready) rdy_hi++;
      if (spike_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL %s unexpected spike: got id %0d expected none", name, spike_id);
        end else begin
          check32($sformatf("%s spike_id", name), 32'(spike_id), 32'(exp_q.pop_front()));
        end
      end
      if (done) seen = 1'b1;
    end
    check32($sformatf("%s done latency", name), 32'(c), 32'(exp_lat));
    check32($sformatf("%s in_ready during drain/fire", name), 32'(rdy_hi), 32'd0);
    check32($sformatf("%s missing spikes", name), 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_pots(input string name, input logic [3:0][31:0] exp);
    logic [31:0] val;
    for (int j = 0; j < N; j++) begin
      read_pot(IW'(j), val);
      check32($sformatf("%s pot[%0d]", name, j), val, exp[j]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check32({name, " in_ready"},    32'(ev.in_ready),   32'd0);
    check32({name, " spike_valid"}, 32'(spike_valid),   32'd0);
    check32({name, " spike_id"},    32'(spike_id),      32'd0);
    check32({name, " spike_vec"},   32'(spike_vec),     32'd0);
    check32({name, " busy"},        32'(busy),          32'd0);
    check32({name, " done"},        32'(done),          32'd0);
    check32({name, " state"},       32'(dbg_state),     32'(ST_IDLE));
    check_pots(name, {32'h0, 32'h0, 32'h0, 32'h0});
  endtask

  initial begin
    // reload, model, thr, pre{3,2,1,0}, exp_vec, post{3,2,1,0}
    vecs[0] = {1'b1, MODEL_HARD, 32'h4220_0000,
               {32'h0, 32'h0, 32'h41A0_0000, 32'h4220_0000}, 4'b0001,
               {32'h0, 32'h0, 32'h41A0_0000, 32'h0}};
    vecs[1] = {1'b1, MODEL_NONE, 32'h4220_0000,
               {32'h0, 32'h42A0_0000, 32'h0, 32'h0}, 4'b0100,
               {32'h0, 32'h42A0_0000, 32'h0, 32'h0}};
    vecs[2] = {1'b0, MODEL_NONE, 32'h4220_0000,
               {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0100,
               {32'h0, 32'h42A0_0000, 32'h0, 32'h0}};
    vecs[3] = {1'b1, MODEL_HARD, 32'h0000_0000,
               {32'hC220_0000, 32'hBF80_0000, 32'h7FC0_0000, 32'h8000_0000}, 4'b0001,
               {32'hC220_0000, 32'hBF80_0000, 32'h7FC0_0000, 32'h0}};
    vecs[4] = {1'b1, MODEL_SOFT, 32'h4220_0000,
               {32'h421C_0000, 32'h7F80_0000, 32'h4220_0000, 32'h42C8_0000}, 4'b0111,
               {32'h421C_0000, 32'h7F80_0000, 32'h0, 32'h4270_0000}};
    vecs[5] = {1'b1, 2'b11, 32'h3F80_0000,
               {32'h3F80_0000, 32'h3F7F_FFFF, 32'h7F7F_FFFF, 32'h0000_0001}, 4'b1010,
               {32'h0, 32'h3F7F_FFFF, 32'h0, 32'h0000_0001}};

    RESET = 1'b0; model = MODEL_HARD; v_threshold = 32'h0;
    ts_start = 1'b0; ts_end = 1'b0; ld_en = 1'b0; ld_id = '0; ld_data = '0; rd_id = '0;
    ev.in_valid = 1'b0; ev.in_id = '0; ev.in_weight = '0;
    step();
    do_reset();
    check_reset_outputs("por");

    // scan-only vectors
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].reload) for (int j = 0; j < N; j++) load_pot(IW'(j), vecs[i].pre[j]);
      model = vecs[i].model;
      v_threshold = vecs[i].thr;
      push_spikes(vecs[i].exp_vec);
      pulse_start();
      pulse_end();
      wait_done($sformatf("vec%0d", i), 0, N + 1);
      check32($sformatf("vec%0d spike_vec", i), 32'(spike_vec), 32'(vecs[i].exp_vec));
      check_pots($sformatf("vec%0d", i), vecs[i].post);
    end

    // three back-to-back events to one neuron, then soft reset
    do_reset();
    model = MODEL_SOFT; v_threshold = 32'h4220_0000;
    pulse_start();
    check32("accum in_ready", 32'(ev.in_ready), 32'd1);
    ev.in_valid = 1'b1; ev.in_id = 2'd1; ev.in_weight = 32'h41A0_0000;
    repeat (3) step();
    ev.in_valid = 1'b0;
    repeat (3) step();
    read_pot(2'd1, v);
    check32("fwd sum id1", v, 32'h4270_0000);
    push_spikes(4'b0010);
    pulse_end();
    wait_done("fwd", 0, N + 1);
    check32("fwd spike_vec", 32'(spike_vec), 32'b0010);
    check_pots("fwd", {32'h0, 32'h0, 32'h41A0_0000, 32'h0});

    // ts_end in the same cycle as an accepted event; loads and ts_start while busy
    do_reset();
    load_pot(2'd0, 32'h41A0_0000);
    model = MODEL_NONE; v_threshold = 32'h41A8_0000;
    push_spikes(4'b0001);
    pulse_start();
    ev.in_valid = 1'b1; ev.in_id = 2'd0; ev.in_weight = 32'h3F80_0000; ts_end = 1'b1;
    step();
    ev.in_valid = 1'b0; ts_end = 1'b0;
    check32("coinc in_ready drain", 32'(ev.in_ready), 32'd0);
    check32("coinc busy drain", 32'(busy), 32'd1);
    ld_en = 1'b1; ld_id = 2'd1; ld_data = 32'h4B00_0000; ts_start = 1'b1;
    step();
    step();
    ld_en = 1'b0; ts_start = 1'b0;
    wait_done("coinc", 2, N + 3);
    check32("coinc state after done", 32'(dbg_state), 32'(ST_IDLE));
    check32("coinc spike_vec", 32'(spike_vec), 32'b0001);
    check_pots("coinc", {32'h0, 32'h0, 32'h0, 32'h41A8_0000});

    // RESET while scanning
    load_pot(2'd1, 32'h4220_0000);
    load_pot(2'd0, 32'h4220_0000);
    model = MODEL_NONE; v_threshold = 32'h4220_0000;
    pulse_start();
    pulse_end();
    for (int k = 0; k < 20 && dbg_state != ST_FIRE; k++) step();
    check32("midfire reached FIRE", 32'(dbg_state), 32'(ST_FIRE));
    step();
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_reset_outputs("midfire");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/potential_adder_array.md
Name: potential_adder_array

Overview:
- Time-multiplexed, parametrised successor to the single-neuron potential adder.
- Holds membrane potentials for NEURONS neurons, all IEEE-754 single precision.
- Accepts a streamed weight-event interface with valid/ready. Each event is accumulated into its target neuron through a 2-stage pipeline.
- At timestep end, scans all neurons against v_threshold, emits spikes and applies the model-selected reset.
- Sits between the spike router/weight fetch and the potential decay unit.

Parameters:
- NEURONS, 4, neuron count (power of 2, range 2..256).
- ID_W, $clog2(NEURONS), neuron index width.
- V_RESET, 32'h00000000, hard-reset and power-on potential.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high
- model  in  2  00 hard reset to V_RESET, 01 soft reset (subtract threshold), 10 no reset, 11 behaves as 00
- v_threshold  in  32  float threshold, sampled every cycle
- ts_start  in  1  pulse; starts accumulation phase
- ts_end  in  1  pulse; ends accumulation, starts fire scan
- in_valid  in  1  weight event valid
- in_ready  out  1  block accepts event
- in_id  in  ID_W  target neuron
- in_weight  in  32  float weight
- ld_en  in  1  decayed-potential write (IDLE only)
- ld_id  in  ID_W  write target
- ld_data  in  32  decayed potential
- rd_id  in  ID_W  combinational read address
- rd_data  out  32  potential[rd_id], combinational
- spike_valid  out  1  one-cycle pulse per firing neuron
- spike_id  out  ID_W  firing neuron index
- spike_vec  out  NEURONS  spikes of last completed timestep
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when scan completes

Behaviour:
- RESET values:
  - every potential = V_RESET
  - state IDLE, pipeline empty
  - in_ready=0, spike_valid=0, spike_id=0, spike_vec=0, busy=0, done=0
- States: IDLE -> ACCUM -> DRAIN -> FIRE -> IDLE.
- IDLE:
  - ld_en writes ld_data into ld_id; ld_en is ignored in every other state.
  - ts_start moves to ACCUM. ts_end is ignored.
- ACCUM:
  - in_ready=1; an event is accepted on in_valid&&in_ready.
  - Stage 1 registers id and weight.
  - Stage 2 reads the potential, adds through the float adder and writes back. Write lands 2 cycles after acceptance.
  - Throughput is 1 event/cycle.
  - Back-to-back events to the same id forward the stage-2 result into the stage-2 operand, so no event is lost.
  - ts_end, even in the same cycle as an accepted event: that event is still accepted, in_ready drops next cycle, go to DRAIN.
- DRAIN: in_ready=0; wait until both pipeline stages are empty, then enter FIRE with scan index 0.
- FIRE: one neuron per cycle, index 0..NEURONS-1.
  - Fire condition: potential >= v_threshold under float compare.
  - On fire: spike_valid=1 with spike_id=index, and the neuron is reset per model:
    - model 00 (and 11): potential = V_RESET
    - model 01: potential = potential - v_threshold, using the same adder with the sign of v_threshold flipped
    - model 10: potential unchanged
  - Non-firing neurons are untouched.
  - After the last index: spike_vec updated to this scan's spikes, done pulses for one cycle, return to IDLE.
  - Scan latency is NEURONS cycles after DRAIN.
- Float compare rules:
  - +0 and -0 are equal.
  - Negative values order by reversed magnitude.
  - A NaN in either operand never fires.
  - Denormals are compared bitwise as ordered magnitudes.
- Adder width: result is 32-bit float as produced by the shared adder; no saturation; overflow to inf is allowed and inf fires.
- Mid-operation handling:
  - ts_start outside IDLE is ignored.
  - RESET mid-timestep discards in-flight events and returns to IDLE with reset values.
  - rd_data reflects the register file, not pipeline contents.

Decomposition:
- Shared package snn_float_pkg holds:
  - float constants (FP_ZERO, FP_SIGN_BIT)
  - model encodings (MODEL_HARD, MODEL_SOFT, MODEL_NONE)
  - state enum
- Float addition uses the team's shared combinational IEEE-754 adder.
- One new sub-module is natural: fp_ge, a combinational float greater-or-equal comparator with the NaN/zero rules above.

Test Plan:
- RESET, ld_en id0=0x42200000 (40.0), id1=0x41A00000 (20.0), v_threshold=0x42200000, model 00 -> scan spikes id0 only; id0 resets to 0x00000000, id1 stays 0x41A00000; spike_vec=4'b0001; done after NEURONS cycles.
- ACCUM: three back-to-back events id1 weight 0x41A00000 (20.0) from potential 0 -> potential 0x42700000 (60.0), proving forwarding; model 01 scan -> spike id1, potential 0x41A00000 (20.0).
- Model 10: id2 loaded 0x42A00000 (80.0) -> spike id2; potential unchanged 0x42A00000; a second timestep with no events spikes id2 again.
- Negative and edge values: id3=0xC2200000 (-40.0), id0=0x80000000 (-0) with threshold 0x00000000, and id1=NaN 0x7FC00000 -> id0 spikes, id1 and id3 do not.
- ts_end coincident with accepted event id0 weight 0x3F800000 (1.0) from 0x41A00000 -> event applied (0x41A80000) before scan; in_ready low during DRAIN/FIRE; ld_en and ts_start ignored while busy.
- RESET asserted during FIRE -> next cycle every output is 0, all potentials read back V_RESET via rd_id, state IDLE.
